// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: owns the PC, fetches words over a req/ready handshake and
// registers {pc+4, instruction, valid} at the IF/ID boundary.
module fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_instr,
  output logic              fetch_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              if_valid_q, if_valid_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [31:0]       if_instr_q, if_instr_d;
  logic              fetch_err_q, fetch_err_d;
  logic [31:0]       hold_buf_q, hold_buf_d;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc   = pc_q + ADDR_W'(4);
  assign mem_req  = (state_q == S_REQ);
  assign mem_addr = {pc_q[ADDR_W-1:2], 2'b00};

  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign fetch_err = fetch_err_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wait_cnt_d  = wait_cnt_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    fetch_err_d = fetch_err_q;
    hold_buf_d  = hold_buf_q;

    unique case (state_q)
      S_REQ: begin
        if (branch_taken) begin
          // Redirect wins over freeze and drops any data returned this cycle.
          pc_d       = branch_addr & ~ADDR_W'(3);
          if_valid_d = 1'b0;
          hold_buf_d = '0;
          wait_cnt_d = '0;
          state_d    = S_REQ;
        end else if (mem_ready) begin
          wait_cnt_d = '0;
          if (freeze) begin
            hold_buf_d = mem_rdata;
            state_d    = S_HOLD;
          end else begin
            if_instr_d = mem_rdata;
            if_pc_d    = pc_inc;
            if_valid_d = 1'b1;
            pc_d       = pc_inc;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (!freeze) begin
            if_valid_d = 1'b0;
          end
          if (wait_cnt_d == CNT_W'(MAX_WAIT)) begin
            state_d     = S_ERR;
            fetch_err_d = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          pc_d       = branch_addr & ~ADDR_W'(3);
          if_valid_d = 1'b0;
          hold_buf_d = '0;
          wait_cnt_d = '0;
          state_d    = S_REQ;
        end else if (!freeze) begin
          if_instr_d = hold_buf_q;
          if_pc_d    = pc_inc;
          if_valid_d = 1'b1;
          pc_d       = pc_inc;
          state_d    = S_REQ;
        end
      end

      S_ERR: begin
        if_valid_d  = 1'b0;
        fetch_err_d = 1'b1;
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      wait_cnt_q  <= '0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_instr_q  <= '0;
      fetch_err_q <= 1'b0;
      hold_buf_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wait_cnt_q  <= wait_cnt_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      fetch_err_q <= fetch_err_d;
      hold_buf_q  <= hold_buf_d;
    end
  end

endmodule
